// File: rtl/j_rotator_pipe.sv
// j_rotator_pipe: one-cycle pipelined rotation of a packed complex sample by
// j^k (or (-j)^k for the inverse transform), with valid/ready handshake,
// saturation of the single non-representable negation and a sticky count of
// saturated output samples.
module j_rotator_pipe #(
    parameter int unsigned W     = 11,
    parameter int unsigned SAT   = 1,
    parameter int unsigned AUTO  = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   in_data,
    input  logic [1:0]       in_rot,
    input  logic             in_inv,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_data,
    output logic             out_last,
    output logic             out_sat,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

    logic             out_valid_q;
    logic [2*W-1:0]   out_data_q;
    logic             out_last_q;
    logic             out_sat_q;
    logic [1:0]       cnt_q;
    logic [CNT_W-1:0] sat_count_q;

    logic             accept;
    logic [W-1:0]     re_in;
    logic [W-1:0]     im_in;
    logic [1:0]       k_sel;
    logic [1:0]       k_eff;
    logic [W:0]       neg_re;
    logic [W:0]       neg_im;
    logic [W-1:0]     re_d;
    logic [W-1:0]     im_d;
    logic             sat_d;

    // Negation returning {overflow_flag, value}; only the most negative
    // input overflows, and it either clamps or wraps back to itself.
    function automatic logic [W:0] neg_f(input logic [W-1:0] x);
        if (x == MIN_V) begin
            return {1'b1, (SAT != 0) ? MAX_V : MIN_V};
        end
        return {1'b0, ~x + 1'b1};
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Rotation datapath: select the effective quarter-turn and swap/negate
    always_comb begin
        re_in  = in_data[2*W-1:W];
        im_in  = in_data[W-1:0];
        k_sel  = (AUTO != 0) ? cnt_q : in_rot;
        // (-j)^k == j^(4-k): the inverse direction is a negated index mod 4
        k_eff  = in_inv ? (2'd0 - k_sel) : k_sel;
        neg_re = neg_f(re_in);
        neg_im = neg_f(im_in);
        re_d   = re_in;
        im_d   = im_in;
        sat_d  = 1'b0;
        case (k_eff)
            2'd0: begin
                re_d  = re_in;
                im_d  = im_in;
                sat_d = 1'b0;
            end
            2'd1: begin
                re_d  = neg_im[W-1:0];
                im_d  = re_in;
                sat_d = neg_im[W];
            end
            2'd2: begin
                re_d  = neg_re[W-1:0];
                im_d  = neg_im[W-1:0];
                sat_d = neg_re[W] | neg_im[W];
            end
            default: begin
                re_d  = im_in;
                im_d  = neg_re[W-1:0];
                sat_d = neg_re[W];
            end
        endcase
    end

    // Output register: loads on accept, drops valid when ready but idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (in_ready) begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_data_q <= {re_d, im_d};
                out_last_q <= in_last;
                out_sat_q  <= sat_d;
            end
        end
    end

    // Auto-sequenced rotation index: advances per accepted sample, block restart on last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= in_last ? 2'd0 : cnt_q + 2'd1;
        end
    end

    // Saturated-sample counter: sticks at all-ones, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else if (sat_clr) begin
            sat_count_q <= '0;
        end else if (accept && sat_d && (sat_count_q != '1)) begin
            sat_count_q <= sat_count_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_j_rotator_pipe.sv
// tb_j_rotator_pipe: scoreboard bench driving three configurations of the
// rotator in lockstep (saturating, wrapping with 2-bit counter, auto index).
module tb_j_rotator_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [21:0] in_data = '0;
    logic [1:0]  in_rot = '0;
    logic        in_inv = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        sat_clr = 1'b0;

    logic        ir [3];
    logic        ov [3];
    logic [21:0] od [3];
    logic        ol [3];
    logic        os [3];
    logic [15:0] sc0;
    logic [1:0]  sc1;
    logic [15:0] sc2;

    always #5 clk = ~clk;

    j_rotator_pipe #(.W(11), .SAT(1), .AUTO(0), .CNT_W(16)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_rot(in_rot), .in_inv(in_inv), .in_last(in_last), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]), .out_sat(os[0]),
        .sat_clr(sat_clr), .sat_count(sc0));

    j_rotator_pipe #(.W(11), .SAT(0), .AUTO(0), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_rot(in_rot), .in_inv(in_inv), .in_last(in_last), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]), .out_sat(os[1]),
        .sat_clr(sat_clr), .sat_count(sc1));

    j_rotator_pipe #(.W(11), .SAT(1), .AUTO(1), .CNT_W(16)) u_auto (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_rot(in_rot), .in_inv(in_inv), .in_last(in_last), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]), .out_sat(os[2]),
        .sat_clr(sat_clr), .sat_count(sc2));

    int n_checks = 0;
    int n_err = 0;

    // Expected record per instance: {data[21:0], last, sat}
    typedef logic [2:0][23:0] ent_t;
    ent_t        sb[$];
    int          sc_exp [3];
    int          pos = 0;
    bit          mon_en = 1'b0;
    bit          hold [3];
    logic [21:0] hold_d [3];

    function automatic bit cfg_sat(input int j);
        return j != 1;
    endfunction

    function automatic bit cfg_auto(input int j);
        return j == 2;
    endfunction

    function automatic int cfg_max(input int j);
        return (j == 1) ? 3 : 65535;
    endfunction

    function automatic int sc_act(input int j);
        case (j)
            0: return int'(sc0);
            1: return int'(sc1);
            default: return int'(sc2);
        endcase
    endfunction

    function automatic logic [21:0] pk(input int r, input int i);
        return {r[10:0], i[10:0]};
    endfunction

    // Reference: multiply (R + jI) by j (or -j) k times in wide integers, then
    // map the single out-of-range value (+2^10) back into 11 bits.
    function automatic logic [23:0] model(input logic [21:0] d, input int k, input bit inv, input bit sat);
        int r;
        int i;
        int t;
        bit f;
        r = $signed(d[21:11]);
        i = $signed(d[10:0]);
        f = 1'b0;
        for (int n = 0; n < k; n++) begin
            t = r;
            if (!inv) begin
                r = -i;
                i = t;
            end else begin
                r = i;
                i = -t;
            end
        end
        if (r > 1023) begin
            f = 1'b1;
            r = sat ? 1023 : -1024;
        end
        if (i > 1023) begin
            f = 1'b1;
            i = sat ? 1023 : -1024;
        end
        return {r[10:0], i[10:0], 1'b0, f};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock of stimulus; expectations are queued only for accepted samples
    task automatic step(input bit v, input logic [21:0] d, input logic [1:0] k, input bit inv,
                        input bit last, input bit ordy, input bit clr, output bit acc);
        ent_t       e;
        int         nxt [3];
        logic [23:0] r;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_rot    = k;
        in_inv    = inv;
        in_last   = last;
        out_ready = ordy;
        sat_clr   = clr;
        #2;
        acc = v && ir[0];
        for (int j = 0; j < 3; j++) begin
            r = model(d, cfg_auto(j) ? pos : int'(k), inv, cfg_sat(j));
            r[1] = last;
            e[j] = r;
            nxt[j] = sc_exp[j];
            if (clr) nxt[j] = 0;
            else if (acc && r[0] && sc_exp[j] < cfg_max(j)) nxt[j] = sc_exp[j] + 1;
        end
        if (acc) begin
            sb.push_back(e);
            pos = last ? 0 : (pos + 1) % 4;
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) sc_exp[j] = nxt[j];
    endtask

    task automatic send(input logic [21:0] d, input logic [1:0] k, input bit inv, input bit last);
        bit acc;
        step(1'b1, d, k, inv, last, 1'b1, 1'b0, acc);
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic idle(input bit ordy, input bit clr);
        bit acc;
        step(1'b0, '0, 2'd0, 1'b0, 1'b0, ordy, clr, acc);
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb.size() > 0; c++) idle(1'b1, 1'b0);
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s_valid_d%0d", tag, j), ov[j], 1'b0);
            chk($sformatf("%s_data_d%0d", tag, j), od[j], 22'd0);
            chk($sformatf("%s_last_d%0d", tag, j), ol[j], 1'b0);
            chk($sformatf("%s_sat_d%0d", tag, j), os[j], 1'b0);
            chk($sformatf("%s_count_d%0d", tag, j), sc_act(j), 0);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        pos = 0;
        for (int j = 0; j < 3; j++) begin
            sc_exp[j] = 0;
            hold[j] = 1'b0;
        end
    endtask

    // Monitor: compares presented outputs against the scoreboard each cycle
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("out_valid_d%0d", j), ov[j], sb.size() > 0);
                    chk($sformatf("in_ready_d%0d", j), ir[j], !(sb.size() > 0) || out_ready);
                    chk($sformatf("sat_count_d%0d", j), sc_act(j), sc_exp[j]);
                    if (hold[j]) chk($sformatf("stall_hold_d%0d", j), od[j], hold_d[j]);
                end
                if (sb.size() > 0 && out_ready) begin
                    e = sb.pop_front();
                    for (int j = 0; j < 3; j++) begin
                        chk($sformatf("out_data_d%0d", j), od[j], e[j][23:2]);
                        chk($sformatf("out_last_d%0d", j), ol[j], e[j][1]);
                        chk($sformatf("out_sat_d%0d", j), os[j], e[j][0]);
                    end
                end
                for (int j = 0; j < 3; j++) begin
                    hold[j]   = ov[j] && !out_ready;
                    hold_d[j] = od[j];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        int          cyc;
        int          tries;
        logic [21:0] d;
        int          r;
        int          i;

        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) chk($sformatf("ready_after_reset_d%0d", j), ir[j], 1'b1);
        mon_en = 1'b1;

        // Auto sequencing: block restart on the third sample
        for (int n = 0; n < 6; n++) send(pk(10, 0), 2'd0, 1'b0, n == 2);
        drain();

        // Fixed rotations, both directions
        for (int inv = 0; inv < 2; inv++)
            for (int k = 0; k < 4; k++) send(pk(100, -37), 2'(k), 1'(inv), 1'b0);
        drain();

        // Most-negative component negations
        send(pk(-1024, 5), 2'd2, 1'b0, 1'b0);
        send(pk(5, -1024), 2'd1, 1'b0, 1'b0);
        send(pk(-1024, -1024), 2'd2, 1'b1, 1'b0);
        send(pk(-1024, 7), 2'd3, 1'b1, 1'b0);
        drain();

        // Backpressure: source holds each sample until accepted
        cyc = 0;
        for (int n = 0; n < 8; n++) begin
            d = pk(n * 50 - 200, 300 - n * 33);
            tries = 0;
            do begin
                step(1'b1, d, 2'(n), 1'(n / 4), 1'b0, !(cyc >= 3 && cyc <= 5), 1'b0, acc);
                cyc++;
                tries++;
            end while (!acc && tries < 10);
            chk("bp_accept", acc, 1'b1);
        end
        drain();

        // Sticky counter then clear coinciding with a saturating accept
        idle(1'b1, 1'b1);
        for (int n = 0; n < 5; n++) send(pk(-1024, 1), 2'd2, 1'b0, 1'b0);
        step(1'b1, pk(-1024, 1), 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        chk("clr_accept", acc, 1'b1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 5) == 0) ? -1024 : int'($urandom_range(0, 2047)) - 1024;
            i = ($urandom_range(0, 5) == 0) ? -1024 : int'($urandom_range(0, 2047)) - 1024;
            step($urandom_range(0, 4) != 0, pk(r, i), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
        end
        drain();

        // Asynchronous reset while an output is stalled
        send(pk(123, -45), 2'd1, 1'b0, 1'b0);
        send(pk(-1024, 3), 2'd2, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("pre_reset_valid", ov[0], 1'b1);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        clear_model();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) chk($sformatf("ready_after_midreset_d%0d", j), ir[j], 1'b1);
        mon_en = 1'b1;

        // Post-reset traffic: auto index restarts at zero
        for (int n = 0; n < 5; n++) send(pk(10 + n, -3), 2'(n), 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
